// File: rtl/error_queue_dispatcher.sv
// error_queue_dispatcher
//   Drains 64-bit error records from the error FIFO read interface and writes
//   each one into a circular queue in system memory through a single-beat
//   write port. Records arriving while the queue is full are still popped so
//   the FIFO never stalls, and they are counted as dropped. A coalesced
//   interrupt is raised on a record-count threshold or on an idle timeout.
//
//   Ports
//     CLK, RESET          clock; synchronous active-high reset
//     ENA                 enable; 0 stops new pops (a record in flight completes)
//     QBASE               queue base (64-bit-word address), sampled per record
//     SW_TAIL, TAIL_STB   software tail index and its load strobe
//     EVALID, ECD, ERD    FIFO valid, record, pop strobe
//     MEM_ACT, MEM_NEXT   write request / write accepted
//     MEM_ADDR, MEM_DATA  write address (QBASE + HEAD) and record
//     HEAD                next queue index to be written
//     IRQ, IRQ_ACK        level interrupt and its acknowledge
//     OVF_CNT             saturating dropped-record count
module error_queue_dispatcher #(
    parameter int unsigned QLOG2   = 8,
    parameter int unsigned THRESH  = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENA,
    input  logic [31:0]      QBASE,
    input  logic [QLOG2-1:0] SW_TAIL,
    input  logic             TAIL_STB,
    input  logic             EVALID,
    input  logic [63:0]      ECD,
    output logic             ERD,
    output logic             MEM_ACT,
    input  logic             MEM_NEXT,
    output logic [31:0]      MEM_ADDR,
    output logic [63:0]      MEM_DATA,
    output logic [QLOG2-1:0] HEAD,
    output logic             IRQ,
    input  logic             IRQ_ACK,
    output logic [15:0]      OVF_CNT
);

    localparam logic [15:0] THRESH_W = 16'(THRESH);
    localparam logic [15:0] TMR_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, POP, WRITE, DROP} state_t;

    state_t           state;
    logic [QLOG2-1:0] tail;
    logic [15:0]      pend;
    logic [15:0]      tmr;

    logic [QLOG2-1:0] head_inc;
    logic             full;
    logic             write_done;
    logic             irq_set;

    // Natural QLOG2-bit wrap gives the modulo-depth increment.
    assign head_inc   = HEAD + 1'b1;
    assign full       = (head_inc == tail);
    assign write_done = (state == WRITE) && MEM_NEXT;
    assign irq_set    = (pend >= THRESH_W) || ((pend != '0) && (tmr == TMR_LAST));

    // Pop strobe is gated by EVALID so a vanished record is never consumed.
    assign ERD = (state == POP) && EVALID;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            MEM_ACT  <= 1'b0;
            MEM_ADDR <= '0;
            MEM_DATA <= '0;
            HEAD     <= '0;
            tail     <= '0;
            IRQ      <= 1'b0;
            OVF_CNT  <= '0;
            pend     <= '0;
            tmr      <= '0;
        end else begin
            if (TAIL_STB) begin
                tail <= SW_TAIL;
            end

            case (state)
                IDLE: begin
                    if (ENA && EVALID) begin
                        state <= POP;
                    end
                end
                POP: begin
                    // MEM_DATA doubles as the record holding register.
                    if (!EVALID) begin
                        state <= IDLE;
                    end else if (full) begin
                        state <= DROP;
                    end else begin
                        state    <= WRITE;
                        MEM_ACT  <= 1'b1;
                        MEM_ADDR <= QBASE + 32'(HEAD);
                        MEM_DATA <= ECD;
                    end
                end
                WRITE: begin
                    if (MEM_NEXT) begin
                        MEM_ACT <= 1'b0;
                        HEAD    <= head_inc;
                        state   <= IDLE;
                    end
                end
                DROP: begin
                    if (OVF_CNT != '1) begin
                        OVF_CNT <= OVF_CNT + 16'd1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Acknowledge dominates a simultaneous set; a write landing in the
            // ack cycle starts the new pending count at one.
            if (IRQ_ACK) begin
                IRQ  <= 1'b0;
                pend <= write_done ? 16'd1 : 16'd0;
                tmr  <= '0;
            end else begin
                if (irq_set) begin
                    IRQ <= 1'b1;
                end
                if (write_done) begin
                    if (pend != '1) begin
                        pend <= pend + 16'd1;
                    end
                    tmr <= '0;
                end else if ((pend != '0) && (state == IDLE) && (tmr != TMR_LAST)) begin
                    tmr <= tmr + 16'd1;
                end
            end
        end
    end

endmodule
